// File: rtl/core_step_controller_if.sv
// Sequencer <-> datapath bundle: master is the step controller, slave the datapath side.
// Retire counter width is carried here so both ends agree on it.
interface core_step_controller_if #(
  parameter int RETIRE_WIDTH = 32
);
  logic                    i_rb_ready;
  logic                    i_mem_r;
  logic                    i_mem_w;
  logic                    i_mem_ready;
  logic                    i_reg_w;
  logic                    i_pc_end;
  logic                    i_halt_req;
  logic                    i_resume;
  logic                    i_step_mode;
  logic                    o_instr_latch;
  logic                    o_mem_req;
  logic                    o_reg_w_en;
  logic                    o_pc_enable;
  logic                    o_halted;
  logic                    o_fault;
  logic [2:0]              o_state;
  logic [RETIRE_WIDTH-1:0] o_retire_count;

  modport master (
    input  i_rb_ready, i_mem_r, i_mem_w, i_mem_ready, i_reg_w,
           i_pc_end, i_halt_req, i_resume, i_step_mode,
    output o_instr_latch, o_mem_req, o_reg_w_en, o_pc_enable,
           o_halted, o_fault, o_state, o_retire_count
  );

  modport slave (
    output i_rb_ready, i_mem_r, i_mem_w, i_mem_ready, i_reg_w,
           i_pc_end, i_halt_req, i_resume, i_step_mode,
    input  o_instr_latch, o_mem_req, o_reg_w_en, o_pc_enable,
           o_halted, o_fault, o_state, o_retire_count
  );
endinterface

// File: rtl/core_step_controller.sv
// RV32I multi-cycle sequencer: 4 cycles per ALU instr, 5+N with N bus wait states.
// MEM stalls on i_mem_ready and faults (sticky) after MEM_TIMEOUT cycles; debug halt/resume/step.
module core_step_controller #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int RETIRE_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  core_step_controller_if.master bus
);
  localparam int            CW       = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_RESET_WAIT = 3'd0,
    S_FETCH      = 3'd1,
    S_DECODE     = 3'd2,
    S_EXECUTE    = 3'd3,
    S_MEM        = 3'd4,
    S_WRITEBACK  = 3'd5,
    S_HALT       = 3'd6,
    S_FAULT      = 3'd7
  } state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_mem_cnt;
  logic [RETIRE_WIDTH-1:0] r_retire;
  logic                    r_in_fetch;
  logic                    r_in_mem;
  logic                    r_in_wb;
  logic                    r_halted;
  logic                    r_fault;
  state_t                  w_next;

  // Losing rb_ready mid-instruction abandons it; HALT and FAULT ignore rb_ready.
  function automatic state_t f_next(
    input state_t        s,
    input logic [CW-1:0] cnt,
    input logic          rb, mr, mw, mrdy, pce, hr, res, sm
  );
    state_t n;
    n = s;
    case (s)
      S_RESET_WAIT: if (rb) n = S_FETCH;
      S_FETCH: begin
        if (!rb)            n = S_RESET_WAIT;
        else if (hr || pce) n = S_HALT;
        else                n = S_DECODE;
      end
      S_DECODE:  n = rb ? S_EXECUTE : S_RESET_WAIT;
      S_EXECUTE: begin
        if (!rb)           n = S_RESET_WAIT;
        else if (mr || mw) n = S_MEM;
        else               n = S_WRITEBACK;
      end
      S_MEM: begin
        if (!rb)                 n = S_RESET_WAIT;
        else if (mrdy)           n = S_WRITEBACK;
        else if (cnt == CNT_LAST) n = S_FAULT;
      end
      S_WRITEBACK: begin
        if (!rb)                n = S_RESET_WAIT;
        else if (hr || pce || sm) n = S_HALT;
        else                    n = S_FETCH;
      end
      S_HALT:  if (res && !pce) n = S_FETCH;
      default: n = S_FAULT;
    endcase
    return n;
  endfunction

  assign w_next = f_next(r_state, r_mem_cnt, bus.i_rb_ready, bus.i_mem_r, bus.i_mem_w,
                         bus.i_mem_ready, bus.i_pc_end, bus.i_halt_req, bus.i_resume,
                         bus.i_step_mode);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RESET_WAIT;
      r_mem_cnt  <= '0;
      r_retire   <= '0;
      r_in_fetch <= 1'b0;
      r_in_mem   <= 1'b0;
      r_in_wb    <= 1'b0;
      r_halted   <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_in_fetch <= (w_next == S_FETCH);
      r_in_mem   <= (w_next == S_MEM);
      r_in_wb    <= (w_next == S_WRITEBACK);
      r_halted   <= (w_next == S_HALT);
      r_fault    <= (w_next == S_FAULT);
      if (r_state == S_EXECUTE)
        r_mem_cnt <= '0;
      else if (r_state == S_MEM)
        r_mem_cnt <= r_mem_cnt + 1'b1;
      if (r_state == S_WRITEBACK && bus.i_rb_ready)
        r_retire <= r_retire + 1'b1;
    end
  end

  // An aborted writeback must neither advance the PC nor write rd.
  assign bus.o_instr_latch  = r_in_fetch & ~(bus.i_halt_req | bus.i_pc_end);
  assign bus.o_mem_req      = r_in_mem;
  assign bus.o_pc_enable    = r_in_wb & bus.i_rb_ready;
  assign bus.o_reg_w_en     = r_in_wb & bus.i_rb_ready & bus.i_reg_w & ~bus.i_mem_w;
  assign bus.o_halted       = r_halted;
  assign bus.o_fault        = r_fault;
  assign bus.o_state        = r_state;
  assign bus.o_retire_count = r_retire;
endmodule

// File: tb/tb_core_step_controller.sv
// Bench for core_step_controller: 32-bit and 4-bit retire-counter instances share one stimulus stream.
// Fixed vector table, directed corner sequences, then random stimulus against a reference model.
module tb_core_step_controller;
  localparam int MEM_TIMEOUT = 16;
  localparam int ST_RW = 0, ST_F = 1, ST_D = 2, ST_E = 3, ST_M = 4, ST_W = 5, ST_H = 6, ST_X = 7;

  typedef struct packed {
    logic rst, rb, mr, mw, mrdy, rw, pce, hr, res, sm;
  } in_t;

  typedef struct packed {
    logic [2:0] st;
    logic       il, mq, pe, rwe, h, f;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
    int   rc;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  in_t  cur;
  out_t oa, ob;
  int   vectors = 0;
  int   fails   = 0;

  int              m_st = 0;
  int              m_memcyc = 0;
  longint unsigned m_ret = 0;

  vec_t tbl[$];

  always #5 clk = ~clk;

  core_step_controller_if #(.RETIRE_WIDTH(32)) ifa ();
  core_step_controller_if #(.RETIRE_WIDTH(4))  ifb ();

  core_step_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .RETIRE_WIDTH(32)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa));
  core_step_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .RETIRE_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb));

  assign rst = cur.rst;
  assign ifa.i_rb_ready = cur.rb;   assign ifb.i_rb_ready = cur.rb;
  assign ifa.i_mem_r = cur.mr;      assign ifb.i_mem_r = cur.mr;
  assign ifa.i_mem_w = cur.mw;      assign ifb.i_mem_w = cur.mw;
  assign ifa.i_mem_ready = cur.mrdy; assign ifb.i_mem_ready = cur.mrdy;
  assign ifa.i_reg_w = cur.rw;      assign ifb.i_reg_w = cur.rw;
  assign ifa.i_pc_end = cur.pce;    assign ifb.i_pc_end = cur.pce;
  assign ifa.i_halt_req = cur.hr;   assign ifb.i_halt_req = cur.hr;
  assign ifa.i_resume = cur.res;    assign ifb.i_resume = cur.res;
  assign ifa.i_step_mode = cur.sm;  assign ifb.i_step_mode = cur.sm;

  assign oa = {ifa.o_state, ifa.o_instr_latch, ifa.o_mem_req, ifa.o_pc_enable,
               ifa.o_reg_w_en, ifa.o_halted, ifa.o_fault};
  assign ob = {ifb.o_state, ifb.o_instr_latch, ifb.o_mem_req, ifb.o_pc_enable,
               ifb.o_reg_w_en, ifb.o_halted, ifb.o_fault};

  // Reference: one instruction walks the pipeline steps; MEM cycles are counted from 1.
  task automatic model_edge(input in_t v);
    if (v.rst) begin
      m_st = ST_RW; m_memcyc = 0; m_ret = 0;
    end else begin
      case (m_st)
        ST_RW: if (v.rb) m_st = ST_F;
        ST_F:  m_st = !v.rb ? ST_RW : ((v.hr || v.pce) ? ST_H : ST_D);
        ST_D:  m_st = v.rb ? ST_E : ST_RW;
        ST_E: begin
          m_memcyc = 0;
          m_st = !v.rb ? ST_RW : ((v.mr || v.mw) ? ST_M : ST_W);
        end
        ST_M: begin
          m_memcyc++;
          if (!v.rb)                         m_st = ST_RW;
          else if (v.mrdy)                   m_st = ST_W;
          else if (m_memcyc == MEM_TIMEOUT)  m_st = ST_X;
        end
        ST_W: begin
          if (!v.rb) m_st = ST_RW;
          else begin
            m_ret++;
            m_st = (v.hr || v.pce || v.sm) ? ST_H : ST_F;
          end
        end
        ST_H: if (v.res && !v.pce) m_st = ST_F;
        default: ;
      endcase
    end
  endtask

  function automatic out_t model_out(input in_t v);
    out_t o;
    o.st  = m_st[2:0];
    o.il  = (m_st == ST_F) && !v.hr && !v.pce;
    o.mq  = (m_st == ST_M);
    o.pe  = (m_st == ST_W) && v.rb;
    o.rwe = (m_st == ST_W) && v.rb && v.rw && !v.mw;
    o.h   = (m_st == ST_H);
    o.f   = (m_st == ST_X);
    return o;
  endfunction

  function automatic vec_t mkv(input in_t i, input int st, input logic [5:0] fl, input int rc);
    vec_t r;
    logic [2:0] s3;
    s3 = st[2:0];
    r.i = i; r.o = {s3, fl}; r.rc = rc;
    return r;
  endfunction

  task automatic cmp(input string nm, input out_t e, input longint unsigned erc);
    logic [31:0] ra;
    logic [3:0]  r4;
    ra = erc[31:0];
    r4 = erc[3:0];
    vectors++;
    if (oa !== e || ob !== e) begin
      fails++;
      $display("FAIL %s t=%0t: {state,il,mq,pe,rwe,h,f} got a=%b b=%b expected %b",
               nm, $time, oa, ob, e);
    end
    vectors++;
    if (ifa.o_retire_count !== ra || ifb.o_retire_count !== r4) begin
      fails++;
      $display("FAIL %s t=%0t: retire_count got a=%0d b=%0d expected %0d/%0d",
               nm, $time, ifa.o_retire_count, ifb.o_retire_count, ra, r4);
    end
  endtask

  task automatic chk(input string nm, input longint got, input longint exp);
    vectors++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s t=%0t: got %0d expected %0d", nm, $time, got, exp);
    end
  endtask

  task automatic cyc(input in_t v, input string nm);
    @(posedge clk); #1;
    model_edge(cur);
    cur = v;
    #1;
    cmp(nm, model_out(v), m_ret);
  endtask

  task automatic do_reset();
    in_t v;
    v = '0; v.rst = 1'b1; v.rb = 1'b1;
    cyc(v, "reset");
    cyc(v, "reset");
    v.rst = 1'b0;
    cyc(v, "reset_release");
  endtask

  task automatic run_mem(input int ready_at, input bit store);
    in_t v;
    int  nmq, npe;
    do_reset();
    v = '0; v.rb = 1'b1; v.rw = 1'b1; v.mw = store; v.mr = !store;
    cyc(v, "mem_fetch"); cyc(v, "mem_decode"); cyc(v, "mem_execute");
    nmq = 0; npe = 0;
    for (int k = 1; k <= 20; k++) begin
      v.mrdy = (k == ready_at);
      cyc(v, "mem_wait");
      if (ifa.o_mem_req) nmq++;
      else break;
    end
    chk("mem_req_cycles", nmq, (ready_at == 0) ? MEM_TIMEOUT : ready_at);
    chk("mem_exit_state", ifa.o_state, (ready_at == 0) ? ST_X : ST_W);
    if (ready_at == 0) begin
      for (int i = 0; i < 6; i++) begin
        v.res = 1'b1; v.rb = (i % 2) == 0;
        cyc(v, "fault_sticky");
        if (ifa.o_pc_enable) npe++;
      end
      chk("fault_held", ifa.o_fault, 1);
      chk("fault_no_pc_enable", npe, 0);
    end
  endtask

  initial begin
    in_t i_rst, i_addi, i_ld, i_ldr, i_st, v;
    bit  dead;
    bit  sm_lvl;

    i_rst  = '0; i_rst.rst = 1'b1; i_rst.rb = 1'b1; i_rst.rw = 1'b1;
    i_addi = '0; i_addi.rb = 1'b1; i_addi.rw = 1'b1;
    i_ld   = i_addi; i_ld.mr = 1'b1;
    i_ldr  = i_ld;   i_ldr.mrdy = 1'b1;
    i_st   = i_addi; i_st.mw = 1'b1; i_st.mrdy = 1'b1;
    cur    = i_rst;

    // {il,mq,pe,rwe,h,f}
    tbl.push_back(mkv(i_rst, ST_RW, 6'b000000, 0));
    tbl.push_back(mkv(i_rst, ST_RW, 6'b000000, 0));
    tbl.push_back(mkv(i_addi, ST_RW, 6'b000000, 0));
    for (int k = 0; k < 3; k++) begin
      tbl.push_back(mkv(i_addi, ST_F, 6'b100000, k));
      tbl.push_back(mkv(i_addi, ST_D, 6'b000000, k));
      tbl.push_back(mkv(i_addi, ST_E, 6'b000000, k));
      tbl.push_back(mkv(i_addi, ST_W, 6'b001100, k));
    end
    tbl.push_back(mkv(i_ld, ST_F, 6'b100000, 3));
    tbl.push_back(mkv(i_ld, ST_D, 6'b000000, 3));
    tbl.push_back(mkv(i_ld, ST_E, 6'b000000, 3));
    for (int k = 0; k < 3; k++) tbl.push_back(mkv(i_ld, ST_M, 6'b010000, 3));
    tbl.push_back(mkv(i_ldr, ST_M, 6'b010000, 3));
    tbl.push_back(mkv(i_ld, ST_W, 6'b001100, 3));
    tbl.push_back(mkv(i_st, ST_F, 6'b100000, 4));
    tbl.push_back(mkv(i_st, ST_D, 6'b000000, 4));
    tbl.push_back(mkv(i_st, ST_E, 6'b000000, 4));
    tbl.push_back(mkv(i_st, ST_M, 6'b010000, 4));
    tbl.push_back(mkv(i_st, ST_W, 6'b001000, 4));
    tbl.push_back(mkv(i_addi, ST_F, 6'b100000, 5));

    foreach (tbl[k]) begin
      @(posedge clk); #1;
      model_edge(cur);
      cur = tbl[k].i;
      #1;
      cmp($sformatf("table[%0d]", k), tbl[k].o, longint'(tbl[k].rc));
    end

    run_mem(0, 1'b1);
    run_mem(MEM_TIMEOUT, 1'b1);
    run_mem(3, 1'b0);

    // halt raised during MEM: instruction still retires, then HALT
    do_reset();
    v = i_ld;
    cyc(v, "hm_f"); cyc(v, "hm_d"); cyc(v, "hm_e"); cyc(v, "hm_m");
    v.hr = 1'b1; cyc(v, "hm_m");
    v.mrdy = 1'b1; cyc(v, "hm_m");
    v.mrdy = 1'b0; cyc(v, "hm_w"); cyc(v, "hm_h");
    chk("halt_after_mem_state", ifa.o_state, ST_H);
    chk("halt_after_mem_retire", ifa.o_retire_count, 1);
    v.hr = 1'b0; v.mr = 1'b0; cyc(v, "hm_idle");
    v.res = 1'b1; cyc(v, "hm_resume");
    v.res = 1'b0; cyc(v, "hm_fetch");
    chk("resume_to_fetch", ifa.o_state, ST_F);

    v.sm = 1'b1;
    repeat (4) cyc(v, "step");
    chk("step_halt_state", ifa.o_state, ST_H);
    chk("step_retire", ifa.o_retire_count, 2);
    for (int n = 0; n < 2; n++) begin
      v.res = 1'b1; cyc(v, "step_resume");
      v.res = 1'b0;
      repeat (5) cyc(v, "step");
      chk("step_halt_state", ifa.o_state, ST_H);
      chk("step_retire", ifa.o_retire_count, 3 + n);
    end

    // rb_ready lost in EXECUTE
    v.sm = 1'b0; v.res = 1'b1; cyc(v, "rb_resume");
    v.res = 1'b0; cyc(v, "rb_f"); cyc(v, "rb_d");
    v.rb = 1'b0; cyc(v, "rb_e"); cyc(v, "rb_abort");
    chk("rb_abort_state", ifa.o_state, ST_RW);
    chk("rb_abort_retire", ifa.o_retire_count, 4);
    v.rb = 1'b1; cyc(v, "rb_wait"); cyc(v, "rb_refetch");
    chk("rb_refetch_state", ifa.o_state, ST_F);

    // counter wrap and pc_end
    do_reset();
    v = i_addi;
    repeat (69) cyc(v, "wrap");
    chk("retire17_w32", ifa.o_retire_count, 17);
    chk("retire17_w4", ifb.o_retire_count, 1);
    cyc(v, "pce_d"); cyc(v, "pce_e");
    v.pce = 1'b1; cyc(v, "pce_w"); cyc(v, "pce_h");
    chk("pc_end_halt", ifa.o_state, ST_H);
    v.res = 1'b1; cyc(v, "pce_resume");
    v.res = 1'b0; cyc(v, "pce_hold");
    chk("resume_ignored_pc_end", ifa.o_state, ST_H);
    v.pce = 1'b0; v.res = 1'b1; cyc(v, "pce_resume2");
    v.res = 1'b0; cyc(v, "pce_fetch");
    chk("resume_after_pc_end", ifa.o_state, ST_F);

    dead = 1'b0; sm_lvl = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 49) == 0) dead = ~dead;
      if ($urandom_range(0, 39) == 0) sm_lvl = ~sm_lvl;
      v = '0;
      v.rst  = ($urandom_range(0, 199) == 0) || (m_st == ST_X && $urandom_range(0, 7) == 0);
      v.rb   = $urandom_range(0, 39) != 0;
      v.mr   = $urandom_range(0, 3) == 0;
      v.mw   = $urandom_range(0, 3) == 0;
      v.mrdy = !dead && ($urandom_range(0, 1) == 1);
      v.rw   = $urandom_range(0, 1) == 1;
      v.pce  = $urandom_range(0, 29) == 0;
      v.hr   = $urandom_range(0, 14) == 0;
      v.res  = $urandom_range(0, 5) == 0;
      v.sm   = sm_lvl;
      cyc(v, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
